tx_command: RTL and testbench
=============================

# tx_command

SPI-side command handler for the coax transmit path. It decodes the TX and TX-status commands from the SPI byte stream and assembles each pair of SPI bytes into a 10-bit coax word. Each completed word is pushed into the transmitter FIFO. It sits between the SPI slave and the TX FIFO, alongside the existing receive-side control logic.

## Interface
- `TX_COMMAND`, default 8'h04: command byte that opens a transmit frame.
- `STATUS_COMMAND`, default 8'h06: command byte that opens a status-read frame.
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `spi_cs`  in  1  SPI chip select, active-low, already synchronized to `clk`; high marks end of frame.
- `spi_rx_data`  in  8  received SPI byte, valid when `spi_rx_strobe`=1.
- `spi_rx_strobe`  in  1  one-cycle pulse per received byte.
- `tx_full`  in  1  TX FIFO full.
- `tx_active`  in  1  coax transmitter currently sending.
- `tx_data`  out  10  word to push into the TX FIFO.
- `tx_load`  out  1  one-cycle FIFO write strobe.
- `spi_tx_data`  out  8  byte returned to the host on the next SPI byte slot.
- `overflow`  out  1  sticky flag: a word was dropped because the FIFO was full.

## Operation
- States:
  - IDLE: waiting for the command byte.
  - TX_HI: expecting the high byte of a word.
  - TX_LO: expecting the low byte of a word.
  - STATUS: status-read frame in progress.
  - IGNORE: unknown command; consume bytes until frame end.
- Transitions from IDLE on a strobe while `spi_cs`=0:
  - byte == `TX_COMMAND` → TX_HI.
  - byte == `STATUS_COMMAND` → STATUS; `spi_tx_data` ← {5'b0, `overflow`, `tx_active`, `tx_full`}.
  - any other byte → IGNORE.
- TX_HI, on strobe: latch `spi_rx_data[1:0]` as word bits [9:8]; bits [7:2] are ignored; → TX_LO.
- TX_LO, on strobe: form word = {hi[1:0], `spi_rx_data`}; → TX_HI.
  - If `tx_full`=0 in the strobe cycle: next cycle `tx_data` ← word and `tx_load`=1.
  - If `tx_full`=1 in the strobe cycle: the word is dropped, `overflow` ← 1, and no load occurs.
- STATUS, on each further strobe: re-capture the status byte. `overflow` clears on the first such strobe after it was reported.
- `spi_cs`=1 in any state → IDLE next cycle. A partially received word (frame ends in TX_LO) is discarded without error.
- Once in IDLE, `spi_tx_data` ← 8'h00 for any frame that is not a status frame.
- Words are pushed only whole. No frame-length limit; an unlimited number of words per frame is allowed.

## Timing
- Reset (`reset`=0) forces, asynchronously:
  - state = IDLE, `tx_data`=0, `tx_load`=0, `spi_tx_data`=0, `overflow`=0.
  - the latched high bits = 0.
- Latency: `tx_load` is asserted exactly 1 cycle after the low-byte strobe, for exactly 1 cycle. `tx_data` is valid in that cycle and held until the next load.
- `spi_tx_data` updates 1 cycle after the command byte strobe. It then holds until the next strobe or until frame end.
- A strobe in the same cycle as `spi_cs`=1 is ignored; frame end wins.
- Back-to-back strobes on consecutive cycles must be handled. The minimum spacing is 1 cycle.
- `overflow` set and clear in the same cycle: set wins.
- Reset asserted mid-frame aborts the frame:
  - no `tx_load` issues after reset.
  - after release, the block waits in IDLE. Bytes of the aborted frame that arrive after release, while `spi_cs` stays 0, are treated as a new command byte followed by payload.

## Test plan
- Reset, `spi_cs`=0, bytes 04,03,FF,01,23 → two `tx_load` pulses, each 1 cycle after its low-byte strobe, with `tx_data`=3FF then 123.
- `tx_full`=1 during the low-byte strobe of frame 04,02,AA → no `tx_load` and `overflow`=1. A following frame 06,00 → `spi_tx_data`=8'h04 with `tx_full`=0 and `tx_active`=0. The second byte clears `overflow`, and a further byte returns 8'h00.
- Frame 04,01 then `spi_cs`=1 → no `tx_load`. Next frame 04,00,55 → single load with `tx_data`=055; the stale high bits are not reused.
- Unknown command 07 followed by bytes 04,00,11 → no `tx_load`, and `spi_tx_data` stays 00.
- Status frame with `tx_active`=1 and `tx_full`=1 → `spi_tx_data`=8'h03 one cycle after the command strobe.
- Reset pulse asserted between the high and low byte of frame 04,02,.. → outputs go to their reset values immediately, and no load occurs for the interrupted word.

Source files
------------

// File: rtl/tx_command_if.sv
// SPI-side and TX-FIFO-side signals of the coax transmit command handler.
interface tx_command_if;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 10;

    logic                spi_cs;
    logic [BYTE_W-1:0]   spi_rx_data;
    logic                spi_rx_strobe;
    logic                tx_full;
    logic                tx_active;
    logic [WORD_W-1:0]   tx_data;
    logic                tx_load;
    logic [BYTE_W-1:0]   spi_tx_data;
    logic                overflow;

    // Host/SPI side plus FIFO status drive the handler.
    modport master (
        output spi_cs, spi_rx_data, spi_rx_strobe, tx_full, tx_active,
        input  tx_data, tx_load, spi_tx_data, overflow
    );

    // The command handler itself.
    modport slave (
        input  spi_cs, spi_rx_data, spi_rx_strobe, tx_full, tx_active,
        output tx_data, tx_load, spi_tx_data, overflow
    );
endinterface

// File: rtl/tx_command.sv
// Decodes TX / TX-status commands from the SPI byte stream and packs byte
// pairs into 10-bit coax words for the transmit FIFO.
module tx_command #(
    parameter logic [7:0] TX_COMMAND     = 8'h04,
    parameter logic [7:0] STATUS_COMMAND = 8'h06
) (
    input  logic         clk,
    input  logic         reset,
    tx_command_if.slave  bus
);
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 10;
    localparam int unsigned HI_W   = WORD_W - BYTE_W;

    typedef enum logic [2:0] {
        IDLE,
        TX_HI,
        TX_LO,
        STATUS,
        IGNORE
    } state_t;

    state_t              state;
    logic [HI_W-1:0]     hi_bits;
    logic [WORD_W-1:0]   tx_data_q;
    logic                tx_load_q;
    logic [BYTE_W-1:0]   spi_tx_data_q;
    logic                overflow_q;
    logic [BYTE_W-1:0]   status_byte_c;

    // Snapshot of the status returned to the host on a status frame.
    assign status_byte_c = {5'b0, overflow_q, bus.tx_active, bus.tx_full};

    // Frame sequencing, word assembly and status reporting.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            hi_bits       <= '0;
            tx_data_q     <= '0;
            tx_load_q     <= 1'b0;
            spi_tx_data_q <= '0;
            overflow_q    <= 1'b0;
        end else begin
            tx_load_q <= 1'b0;
            if (bus.spi_cs) begin
                // Frame end wins over a coincident strobe; partial words are dropped.
                state         <= IDLE;
                hi_bits       <= '0;
                spi_tx_data_q <= '0;
            end else if (bus.spi_rx_strobe) begin
                case (state)
                    IDLE: begin
                        if (bus.spi_rx_data == TX_COMMAND) begin
                            state         <= TX_HI;
                            spi_tx_data_q <= '0;
                        end else if (bus.spi_rx_data == STATUS_COMMAND) begin
                            state         <= STATUS;
                            spi_tx_data_q <= status_byte_c;
                        end else begin
                            state         <= IGNORE;
                            spi_tx_data_q <= '0;
                        end
                    end
                    TX_HI: begin
                        hi_bits <= bus.spi_rx_data[HI_W-1:0];
                        state   <= TX_LO;
                    end
                    TX_LO: begin
                        state <= TX_HI;
                        if (bus.tx_full) begin
                            overflow_q <= 1'b1;
                        end else begin
                            tx_data_q <= {hi_bits, bus.spi_rx_data};
                            tx_load_q <= 1'b1;
                        end
                    end
                    STATUS: begin
                        // Overflow was reported by the previous status byte, so clear it now.
                        spi_tx_data_q <= status_byte_c;
                        overflow_q    <= 1'b0;
                    end
                    IGNORE: begin
                        state <= IGNORE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.tx_data     = tx_data_q;
    assign bus.tx_load     = tx_load_q;
    assign bus.spi_tx_data = spi_tx_data_q;
    assign bus.overflow    = overflow_q;
endmodule

// File: tb/tb_tx_command.sv
// Self-checking bench for tx_command: frame-level reference model plus
// directed frames with hand-computed expectations.
module tb_tx_command;
    logic clk;
    logic reset;

    tx_command_if bus ();

    tx_command dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int bad;
    int dut_loads;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks position of each byte within its frame.
    int         m_idx;
    logic [7:0] m_cmd;
    logic [7:0] m_prev;
    logic       m_load;
    logic [9:0] m_data;
    logic [7:0] m_spi;
    logic       m_ovf;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_idx  = 0;
            m_cmd  = 8'h00;
            m_prev = 8'h00;
            m_load = 1'b0;
            m_data = 10'h000;
            m_spi  = 8'h00;
            m_ovf  = 1'b0;
        end else begin
            m_load = 1'b0;
            if (bus.spi_cs) begin
                m_idx = 0;
                m_spi = 8'h00;
            end else if (bus.spi_rx_strobe) begin
                if (m_idx == 0) begin
                    m_cmd = bus.spi_rx_data;
                    m_spi = (m_cmd == 8'h06) ? {5'b0, m_ovf, bus.tx_active, bus.tx_full} : 8'h00;
                end else if (m_cmd == 8'h04) begin
                    if ((m_idx % 2) == 1) begin
                        m_prev = bus.spi_rx_data;
                    end else if (bus.tx_full) begin
                        m_ovf = 1'b1;
                    end else begin
                        m_load = 1'b1;
                        m_data = {m_prev[1:0], bus.spi_rx_data};
                    end
                end else if (m_cmd == 8'h06) begin
                    m_spi = {5'b0, m_ovf, bus.tx_active, bus.tx_full};
                    m_ovf = 1'b0;
                end
                m_idx++;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("tx_load",     32'(bus.tx_load),     32'(m_load));
        check("tx_data",     32'(bus.tx_data),     32'(m_data));
        check("spi_tx_data", 32'(bus.spi_tx_data), 32'(m_spi));
        check("overflow",    32'(bus.overflow),    32'(m_ovf));
        if (bus.tx_load === 1'b1) dut_loads++;
    end

    // Present one byte for one cycle, then idle for gap cycles.
    task automatic send(input logic [7:0] b, input int gap);
        bus.spi_rx_data   = b;
        bus.spi_rx_strobe = 1'b1;
        @(posedge clk); #1;
        bus.spi_rx_strobe = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic end_frame();
        bus.spi_cs = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.spi_cs = 1'b0;
        @(posedge clk); #1;
    endtask

    int base;

    initial begin
        total = 0;
        bad = 0;
        dut_loads = 0;
        reset = 1'b0;
        bus.spi_cs = 1'b1;
        bus.spi_rx_data = 8'h00;
        bus.spi_rx_strobe = 1'b0;
        bus.tx_full = 1'b0;
        bus.tx_active = 1'b0;
        #1;
        check("rst_tx_data", 32'(bus.tx_data), 32'h0);
        check("rst_tx_load", 32'(bus.tx_load), 32'h0);
        check("rst_spi", 32'(bus.spi_tx_data), 32'h0);
        check("rst_ovf", 32'(bus.overflow), 32'h0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        bus.spi_cs = 1'b0;
        @(posedge clk); #1;

        // Two back-to-back words.
        base = dut_loads;
        send(8'h04, 0);
        send(8'h03, 0);
        send(8'hFF, 0);
        check("w1_load", 32'(bus.tx_load), 32'h1);
        check("w1_data", 32'(bus.tx_data), 32'h3FF);
        send(8'h01, 0);
        check("w1_gap", 32'(bus.tx_load), 32'h0);
        send(8'h23, 0);
        check("w2_load", 32'(bus.tx_load), 32'h1);
        check("w2_data", 32'(bus.tx_data), 32'h123);
        @(posedge clk); #1;
        check("w2_pulse", 32'(bus.tx_load), 32'h0);
        check("w2_hold", 32'(bus.tx_data), 32'h123);
        end_frame();
        check("t1_loads", 32'(dut_loads - base), 32'd2);

        // Drop on full FIFO, then status read clears overflow.
        base = dut_loads;
        send(8'h04, 1);
        send(8'h02, 1);
        bus.tx_full = 1'b1;
        send(8'hAA, 0);
        bus.tx_full = 1'b0;
        check("full_noload", 32'(bus.tx_load), 32'h0);
        check("full_ovf", 32'(bus.overflow), 32'h1);
        end_frame();
        check("t2_loads", 32'(dut_loads - base), 32'd0);
        send(8'h06, 0);
        check("stat_ovf", 32'(bus.spi_tx_data), 32'h04);
        send(8'h00, 1);
        check("stat_clr", 32'(bus.overflow), 32'h0);
        send(8'h00, 1);
        check("stat_after", 32'(bus.spi_tx_data), 32'h00);
        end_frame();
        check("frame_end_spi", 32'(bus.spi_tx_data), 32'h00);

        // Partial word discarded; stale high bits not reused.
        base = dut_loads;
        send(8'h04, 0);
        send(8'h01, 0);
        end_frame();
        send(8'h04, 0);
        send(8'h00, 0);
        send(8'h55, 0);
        check("p_data", 32'(bus.tx_data), 32'h055);
        end_frame();
        check("t3_loads", 32'(dut_loads - base), 32'd1);

        // Unknown command swallows the frame.
        base = dut_loads;
        send(8'h07, 0);
        send(8'h04, 0);
        send(8'h00, 0);
        send(8'h11, 0);
        check("unk_spi", 32'(bus.spi_tx_data), 32'h00);
        end_frame();
        check("t4_loads", 32'(dut_loads - base), 32'd0);

        // Status with active transmitter and full FIFO.
        bus.tx_active = 1'b1;
        bus.tx_full = 1'b1;
        send(8'h06, 2);
        check("stat_busy", 32'(bus.spi_tx_data), 32'h03);
        bus.tx_active = 1'b0;
        bus.tx_full = 1'b0;
        end_frame();

        // Strobe coinciding with frame end is ignored.
        base = dut_loads;
        send(8'h04, 0);
        send(8'h01, 0);
        bus.spi_cs = 1'b1;
        send(8'h22, 0);
        bus.spi_cs = 1'b0;
        @(posedge clk); #1;
        send(8'h33, 1);
        check("cs_win", 32'(dut_loads - base), 32'd0);
        end_frame();

        // Reset between high and low byte aborts the word.
        base = dut_loads;
        send(8'h04, 0);
        send(8'h02, 3);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_data", 32'(bus.tx_data), 32'h0);
        check("mid_rst_spi", 32'(bus.spi_tx_data), 32'h0);
        check("mid_rst_ovf", 32'(bus.overflow), 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        send(8'h33, 0);
        send(8'h44, 2);
        check("mid_rst_loads", 32'(dut_loads - base), 32'd0);
        end_frame();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
